// File: rtl/niosii_system_nios2_qsys_oci_dct_packer.sv
// Delay-compressed-trace packer for the Nios II OCI trace path.
//
// Packs 2-bit trace atoms, oldest at the MSB side, into a 30-bit buffer of up to 15 atoms.
// A frame is queued when the buffer fills or on flush. Frames go into a small circular
// frame FIFO that drains to the trace memory writer.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   atom_valid, atom      - one trace atom per cycle, no backpressure
//   flush                 - push the partial buffer (with any same-cycle atom) as one frame
//   frame_valid/data/count, frame_ready - FIFO head and valid/ready handshake
//   dct_buffer, dct_count - live packing buffer and fill level (0..14)
//   overflow, drop_count  - sticky drop flag and saturating drop counter
//   overflow_clr          - clears overflow and drop_count, wins over a same-cycle drop
module niosii_system_nios2_qsys_oci_dct_packer #(
   parameter int unsigned OUT_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        atom_valid,
   input  logic [1:0]  atom,
   input  logic        flush,
   output logic        frame_valid,
   output logic [29:0] frame_data,
   output logic [3:0]  frame_count,
   input  logic        frame_ready,
   output logic [29:0] dct_buffer,
   output logic [3:0]  dct_count,
   output logic        overflow,
   input  logic        overflow_clr,
   output logic [7:0]  drop_count
);

   localparam int unsigned AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

   logic [29:0]   buf_q, buf_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [33:0]   mem_q [OUT_DEPTH];
   logic [33:0]   mem_d [OUT_DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   occ_q, occ_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    drop_q, drop_d;

   logic [29:0] buf_app;
   logic [3:0]  cnt_app;
   logic        push, pop, push_ok, full;
   logic [33:0] push_word;

   // Packing buffer and push request
   always_comb begin
      buf_app   = {buf_q[27:0], atom};
      cnt_app   = cnt_q + 4'd1;
      buf_d     = buf_q;
      cnt_d     = cnt_q;
      push      = 1'b0;
      push_word = '0;
      if (atom_valid) begin
         if (flush || (cnt_app == 4'd15)) begin
            // Atom first, then a single frame of cnt_app atoms
            push      = 1'b1;
            push_word = {buf_app, cnt_app};
            buf_d     = '0;
            cnt_d     = '0;
         end else begin
            buf_d = buf_app;
            cnt_d = cnt_app;
         end
      end else if (flush && (cnt_q != 4'd0)) begin
         push      = 1'b1;
         push_word = {buf_q, cnt_q};
         buf_d     = '0;
         cnt_d     = '0;
      end
   end

   // Frame FIFO; a pop frees its slot for a same-cycle push into a full FIFO
   always_comb begin
      full    = (occ_q == (AW+1)'(OUT_DEPTH));
      pop     = (occ_q != '0) && frame_ready;
      push_ok = push && (!full || pop);
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      occ_d   = occ_q;
      if (push_ok) begin
         mem_d[wptr_q] = push_word;
         wptr_d        = wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      if (push_ok && !pop) begin
         occ_d = occ_q + 1'b1;
      end else if (!push_ok && pop) begin
         occ_d = occ_q - 1'b1;
      end
   end

   // Overflow tracking
   always_comb begin
      ovf_d  = ovf_q;
      drop_d = drop_q;
      if (overflow_clr) begin
         ovf_d  = 1'b0;
         drop_d = '0;
      end else if (push && !push_ok) begin
         ovf_d = 1'b1;
         if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_q  <= '0;
         cnt_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         occ_q  <= '0;
         ovf_q  <= 1'b0;
         drop_q <= '0;
         for (int i = 0; i < OUT_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         buf_q  <= buf_d;
         cnt_q  <= cnt_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         occ_q  <= occ_d;
         ovf_q  <= ovf_d;
         drop_q <= drop_d;
         for (int i = 0; i < OUT_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign frame_valid = (occ_q != '0);
   assign frame_data  = mem_q[rptr_q][33:4];
   assign frame_count = mem_q[rptr_q][3:0];
   assign dct_buffer  = buf_q;
   assign dct_count   = cnt_q;
   assign overflow    = ovf_q;
   assign drop_count  = drop_q;

endmodule

// File: doc/niosii_system_nios2_qsys_oci_dct_packer.md
# niosII_system_nios2_qsys_oci_dct_packer

Delay-compressed-trace (DCT) packer for the Nios II OCI trace path. It accepts one 2-bit trace atom per cycle from the CPU trace encoder and packs up to 15 atoms into a 30-bit buffer. Completed or flushed buffers go into a small frame FIFO that drains to the trace memory writer. The live packing buffer and fill count are also exported as `dct_buffer` / `dct_count` for the OCI test bench.

## Interface

Parameters:
- `OUT_DEPTH`, default 4: frame FIFO depth in entries; must be a power of two, minimum 2.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `reset`, in, 1: synchronous, active-high reset.
- `atom_valid`, in, 1: `atom` is presented this cycle. There is no backpressure.
- `atom`, in, 2: trace atom code. All four codes are legal.
- `flush`, in, 1: one-cycle pulse that forces the partial buffer out as a frame.
- `frame_valid`, out, 1: the FIFO head is valid.
- `frame_data`, out, 30: FIFO head payload.
- `frame_count`, out, 4: number of atoms in the FIFO head, 1..15.
- `frame_ready`, in, 1: the consumer accepts the head.
- `dct_buffer`, out, 30: live packing buffer.
- `dct_count`, out, 4: live atom count, 0..14.
- `overflow`, out, 1: sticky; set when a frame is dropped.
- `overflow_clr`, in, 1: clears `overflow` and `drop_count`.
- `drop_count`, out, 8: number of dropped frames; saturates at 255.

## Operation

- **Atom accept.** When `atom_valid` is high: `buf_next = {dct_buffer[27:0], atom}` and `cnt_next = dct_count + 1`. The oldest atom ends up at the MSB side.
- **Full emit.** If `cnt_next == 15`, push `{buf_next, 4'd15}`. In the same cycle `dct_buffer <= 0` and `dct_count <= 0`. `dct_count` therefore never shows 15.
- **Flush.**
  - With `atom_valid` low and `dct_count > 0`: push `{dct_buffer, dct_count}` and clear the buffer.
  - With `dct_count == 0` and no atom: no-op.
- **Atom and flush in the same cycle.** The atom is appended first, then one frame of `cnt_next` atoms is pushed (a single push, even when `cnt_next == 15`).
- **Unused upper bits.** In a partial frame the bits above `2*count` are 0.
- **Push onto a full FIFO.**
  - The frame is discarded.
  - `overflow <= 1` and `drop_count` increments, saturating at 255.
  - The packing buffer still clears.
  - Exception: if a pop happens in the same cycle, the push succeeds (a pop frees the slot before the push).
- **FIFO.**
  - Circular buffer with read and write pointers plus an occupancy counter of `log2(OUT_DEPTH)+1` bits. Pointers wrap modulo `OUT_DEPTH`.
  - `frame_valid = (occupancy != 0)`.
  - Pop when `frame_valid && frame_ready`.
  - `frame_data` and `frame_count` are stable while `frame_valid` is high and `frame_ready` is low.
- **overflow_clr.** Takes priority over a drop in the same cycle: the result is `overflow = 0`, `drop_count = 0`.

## Timing

- **Reset values:** `dct_buffer = 0`, `dct_count = 0`, FIFO empty, `frame_valid = 0`, `frame_data = 0`, `frame_count = 0`, `overflow = 0`, `drop_count = 0`.
- **Reset mid-fill:** the partial buffer is discarded with no frame emitted, and the FIFO contents are lost.
- `dct_buffer` / `dct_count` update on the clock edge on which the atom is sampled.
- **Push-to-visible latency is 1 cycle.** A frame pushed at edge N shows `frame_valid = 1` after edge N when the FIFO was empty.
- **Throughput:**
  - Accepts one atom every cycle indefinitely.
  - Sustains one pop per cycle.
  - Simultaneous push and pop leaves the occupancy unchanged.
- **Handshake:** a beat transfers on any edge where `frame_valid && frame_ready`. `frame_ready` may be high while `frame_valid` is low; no transfer occurs.
- All outputs are registered. No combinational path from `frame_ready` to any output except through the registered FIFO state.

## Test plan

- **Full frame.** 15 consecutive atoms of `2'b01`, `frame_ready = 1` → one beat with `frame_data = 30'h15555555` and `frame_count = 15`, one cycle after the 15th atom. `dct_count` then reads 0.
- **Partial flush.** Atoms 3, 2, 1, then `flush` alone → beat with `frame_data = 30'h39`, `frame_count = 3`. `dct_buffer` then reads 0.
- **Atom with flush.** `dct_count = 2` (atoms 1, 1), then atom 2 together with `flush` → `frame_data = 30'h16`, `frame_count = 3`. Exactly one push.
- **Overflow.** `OUT_DEPTH = 4`, `frame_ready = 0`, five frames of one atom each (atom plus flush) → 4 frames held, `overflow = 1`, `drop_count = 1`. Drain with `frame_ready = 1` → 4 beats in order with no gaps. Then `overflow_clr` → `overflow = 0`, `drop_count = 0`.
- **Full FIFO, push with pop.** Full FIFO, a push in the same cycle as a pop → no drop, occupancy stays 4, and the new frame arrives last.
- **Reset mid-fill.** Assert `reset` after 7 atoms → `dct_count = 0`, no beat emitted, all outputs at their reset values on the next cycle.
